// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    FETCH   = 2'd1,
    DELIVER = 2'd2,
    HALT    = 2'd3
  } fetch_state_t;

  localparam logic [1:0]  ERR_NONE     = 2'b00;
  localparam logic [1:0]  ERR_MISALIGN = 2'b01;
  localparam logic [1:0]  ERR_TIMEOUT  = 2'b10;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/next_pc_calc.sv
// Next fetch address from the retiring instruction's redirect information.
// Priority: jr, then jump, then taken branch, then sequential.
module next_pc_calc
  import fetch_pkg::*;
(
  input  logic [31:0] instr_pc,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] next_pc,
  output logic        misaligned
);

  logic [31:0] pc4;

  assign pc4 = instr_pc + PC_STEP;

  // Select the redirect target; all arithmetic wraps modulo 2^32.
  always_comb begin
    next_pc = pc4;
    if (jr)
      next_pc = jr_target;
    else if (jump)
      next_pc = {pc4[31:28], jump_index, 2'b00};
    else if (branch_taken)
      next_pc = pc4 + {branch_offset[29:0], 2'b00};
  end

  assign misaligned = (next_pc[1:0] != 2'b00);

endmodule

// File: rtl/fetch_sequencer.sv
// Sequenced fetch engine: drives the imem request/ack handshake, holds each
// fetched instruction for decode and resolves the next PC at retire.
//
// state   | meaning
// BOOT    | first cycle after reset, load start_pc
// FETCH   | imem_req high, waiting for imem_ack (timeout watched)
// DELIVER | instruction held for decode until instr_ready
// HALT    | sticky error, left only through reset
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] start_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        error,
  output logic [1:0]  error_code,
  output logic [31:0] retire_count
);

  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [7:0]   tmo_cnt;
  logic [7:0]   tmo_next;
  logic [31:0]  next_pc;
  logic         next_misaligned;

  assign imem_addr = pc;
  assign tmo_next  = tmo_cnt + 8'd1;

  next_pc_calc u_next_pc (
    .instr_pc      (instr_pc),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_index    (jump_index),
    .jr            (jr),
    .jr_target     (jr_target),
    .next_pc       (next_pc),
    .misaligned    (next_misaligned)
  );

  // Sequencer FSM with registered handshake and error outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= BOOT;
      pc           <= '0;
      instr        <= '0;
      instr_pc     <= '0;
      imem_req     <= 1'b0;
      instr_valid  <= 1'b0;
      error        <= 1'b0;
      error_code   <= ERR_NONE;
      retire_count <= '0;
      tmo_cnt      <= '0;
    end else if (flush && (state == FETCH || state == DELIVER)) begin
      // A flush wins over a same-cycle ack or retire.
      instr_valid <= 1'b0;
      tmo_cnt     <= '0;
      if (flush_pc[1:0] != 2'b00) begin
        imem_req   <= 1'b0;
        error      <= 1'b1;
        error_code <= ERR_MISALIGN;
        state      <= HALT;
      end else begin
        pc       <= flush_pc;
        imem_req <= 1'b1;
        state    <= FETCH;
      end
    end else begin
      case (state)
        BOOT: begin
          pc <= start_pc;
          if (start_pc[1:0] != 2'b00) begin
            error      <= 1'b1;
            error_code <= ERR_MISALIGN;
            state      <= HALT;
          end else begin
            imem_req <= 1'b1;
            state    <= FETCH;
          end
        end
        FETCH: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            instr_pc    <= pc;
            tmo_cnt     <= '0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
            state       <= DELIVER;
          end else begin
            tmo_cnt <= tmo_next;
            if (tmo_next == TMO_LIMIT) begin
              imem_req   <= 1'b0;
              error      <= 1'b1;
              error_code <= ERR_TIMEOUT;
              state      <= HALT;
            end
          end
        end
        DELIVER: begin
          if (instr_ready) begin
            retire_count <= retire_count + 32'd1;
            instr_valid  <= 1'b0;
            if (next_misaligned) begin
              error      <= 1'b1;
              error_code <= ERR_MISALIGN;
              state      <= HALT;
            end else begin
              pc       <= next_pc;
              imem_req <= 1'b1;
              state    <= FETCH;
            end
          end
        end
        HALT: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
          error       <= 1'b1;
        end
      endcase
    end
  end

endmodule
